wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port between two requesters: the in-order pipeline writeback (MEM/WB) and a long-latency unit (LLU, multi-cycle mul/div) that returns results out of band.
- LLU results are buffered in a small FIFO.
- A pending-register scoreboard produces a decode stall for RAW/WAW hazards against in-flight LLU ops.
- A starvation FSM holds the pipeline when the FIFO has waited too long.
- Sits between MEM/WB, the LLU and the regfile write port; hazard_stall_o is ORed into the decode-stage stall, wb_hold_o into busywait.

Parameters:
DATA_W, 32, register data width
FIFO_DEPTH, 2, LLU result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive lost arbitration cycles before a forced FIFO grant

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
pipe_wb_en_i  in  1  pipeline writeback request
pipe_wb_rd_i  in  5  pipeline destination register
pipe_wb_data_i  in  DATA_W  pipeline writeback data
llu_issue_i  in  1  LLU op dispatched this cycle; marks llu_issue_rd_i pending
llu_issue_rd_i  in  5  destination of the dispatched LLU op
llu_valid_i  in  1  LLU result valid
llu_rd_i  in  5  LLU result destination
llu_data_i  in  DATA_W  LLU result data
llu_ready_o  out  1  FIFO can accept; transfer when llu_valid_i & llu_ready_o
rs1_label_i  in  5  decode rs1
rs2_label_i  in  5  decode rs2
rd_label_i  in  5  decode rd (WAW check)
hazard_stall_o  out  1  decode must stall
wb_hold_o  out  1  pipeline writeback held this cycle
rf_we_o  out  1  regfile write enable
rf_rd_o  out  5  regfile write address
rf_data_o  out  DATA_W  regfile write data
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i low, async): FIFO empty, scoreboard cleared, starve counter 0, FSM IDLE. While rst_i is low: rf_we_o=0, rf_rd_o=0, rf_data_o=0, wb_hold_o=0, hazard_stall_o=0, llu_ready_o=0, fifo_count_o=0. In-flight FIFO contents are discarded.
- Pipe request: pipe_wb_en_i & (pipe_wb_rd_i != 0). A request with rd=x0 is ignored and never wins arbitration.
- LLU enqueue: on an edge with llu_valid_i & llu_ready_o. If llu_rd_i=0, the entry is dropped and its scoreboard clear is skipped.
- llu_ready_o = (count < FIFO_DEPTH). There is no same-cycle pass-through when full.
- A result enqueued at edge N can write the regfile no earlier than cycle N+1.
- Write port outputs are combinational from the selected source:
  - Pipe grant: rf_we_o=1, rf_rd_o=pipe_wb_rd_i, rf_data_o=pipe_wb_data_i.
  - FIFO grant: FIFO head is written and dequeued at the edge.
  - Neither: rf_we_o=0, rf_rd_o=0, rf_data_o=0.
- FSM states:
  - IDLE (FIFO empty): pipe request granted if present.
  - DRAIN (FIFO non-empty, starve<STARVE_LIMIT): pipe request wins; otherwise FIFO head granted.
    - Starve counter increments on each cycle with the FIFO non-empty and a pipe request granted.
    - Counter clears on any dequeue.
  - FORCE (entered when starve==STARVE_LIMIT): wb_hold_o=1 combinationally, FIFO head granted, pipe request not written.
    - The pipeline keeps its writeback inputs stable while held.
    - FORCE lasts exactly one cycle. Counter clears; next state is DRAIN if the FIFO is still non-empty, else IDLE.
  - Transitions are evaluated on FIFO count after enqueue and dequeue at the same edge.
- Simultaneous enqueue and dequeue: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard: 32-bit pending vector; bit 0 is hard-wired 0.
  - Set: bit llu_issue_rd_i set at the edge when llu_issue_i is high.
  - Clear: bit rf_rd_o cleared at the edge when a FIFO entry is written.
  - Same-cycle set and clear on the same register: set wins.
- hazard_stall_o = pending[rs1_label_i] | pending[rs2_label_i] | pending[rd_label_i]. Combinational from registered state; index 0 always reads 0.
- A pipeline write to a pending register cannot occur: the WAW stall prevents it. Behaviour is undefined if the decode stall is ignored.

Test Plan:
- Reset: assert rst_i low mid-operation with FIFO count=1 and pending[5]=1 -> all outputs 0 immediately (async); after release count=0, pending cleared, first write comes from the pipe.
- Idle LLU return: llu_valid_i with rd=7, data=0xDEADBEEF, no pipe traffic -> next cycle rf_we_o=1, rf_rd_o=7, rf_data_o=0xDEADBEEF; count returns to 0; pending[7] clears.
- Collision: pipe rd=3 every cycle while the FIFO holds rd=9 -> pipe wins 4 cycles; cycle 5 wb_hold_o=1 and the rd=9 write; cycle 6 the held pipe rd=3 write.
- Backpressure: fill 2 entries with pipe always requesting -> llu_ready_o=0 at count=2; llu_valid_i held is not lost; ready rises after the forced dequeue.
- Scoreboard: issue rd=12, then decode rs2=12 -> hazard_stall_o=1 until the cycle after the rd=12 FIFO write; rs1=0 with any pending register -> no stall from rs1.
- Set/clear race: FIFO writes rd=4 in the same cycle llu_issue_i issues rd=4 -> pending[4] stays 1.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the write-port arbiter and its surroundings: MEM/WB writeback,
// LLU issue/return, decode hazard labels and the regfile write port.
interface wb_port_arbiter_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              pipe_wb_en_i;
    logic [4:0]        pipe_wb_rd_i;
    logic [DATA_W-1:0] pipe_wb_data_i;
    logic              llu_issue_i;
    logic [4:0]        llu_issue_rd_i;
    logic              llu_valid_i;
    logic [4:0]        llu_rd_i;
    logic [DATA_W-1:0] llu_data_i;
    logic              llu_ready_o;
    logic [4:0]        rs1_label_i;
    logic [4:0]        rs2_label_i;
    logic [4:0]        rd_label_i;
    logic              hazard_stall_o;
    logic              wb_hold_o;
    logic              rf_we_o;
    logic [4:0]        rf_rd_o;
    logic [DATA_W-1:0] rf_data_o;
    logic [CNT_W-1:0]  fifo_count_o;

    // Arbiter side.
    modport slave (
        input  pipe_wb_en_i, pipe_wb_rd_i, pipe_wb_data_i,
        input  llu_issue_i, llu_issue_rd_i,
        input  llu_valid_i, llu_rd_i, llu_data_i,
        input  rs1_label_i, rs2_label_i, rd_label_i,
        output llu_ready_o, hazard_stall_o, wb_hold_o,
        output rf_we_o, rf_rd_o, rf_data_o, fifo_count_o
    );

    // Pipeline / LLU / regfile side.
    modport master (
        output pipe_wb_en_i, pipe_wb_rd_i, pipe_wb_data_i,
        output llu_issue_i, llu_issue_rd_i,
        output llu_valid_i, llu_rd_i, llu_data_i,
        output rs1_label_i, rs2_label_i, rd_label_i,
        input  llu_ready_o, hazard_stall_o, wb_hold_o,
        input  rf_we_o, rf_rd_o, rf_data_o, fifo_count_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a pending-register scoreboard and a starvation-forced FIFO grant.
module wb_port_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StDrain, StForce} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [31:0]       pending_q, pending_d;
    logic [4:0]        mem_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];

    logic              pipe_req, llu_ready, enq, pipe_gnt, fifo_gnt;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [DATA_W-1:0] rf_data;

    assign pipe_req  = bus.pipe_wb_en_i & (bus.pipe_wb_rd_i != 5'd0);
    assign llu_ready = rst_i & (cnt_q < CNT_W'(FIFO_DEPTH));
    // Results to x0 complete the handshake but are never stored.
    assign enq       = bus.llu_valid_i & llu_ready & (bus.llu_rd_i != 5'd0);

    // Select the write-port source from the registered state.
    always_comb begin
        pipe_gnt = 1'b0;
        fifo_gnt = 1'b0;
        unique case (state_q)
            StIdle:  pipe_gnt = pipe_req;
            StDrain: begin
                if (pipe_req) pipe_gnt = 1'b1;
                else          fifo_gnt = (cnt_q != '0);
            end
            StForce: fifo_gnt = (cnt_q != '0);
            default: ;
        endcase
    end

    // Drive the write port from whichever source won; all zero while in reset.
    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = 5'd0;
        rf_data = '0;
        if (rst_i) begin
            if (pipe_gnt) begin
                rf_we   = 1'b1;
                rf_rd   = bus.pipe_wb_rd_i;
                rf_data = bus.pipe_wb_data_i;
            end else if (fifo_gnt) begin
                rf_we   = 1'b1;
                rf_rd   = mem_rd[rd_ptr_q];
                rf_data = mem_data[rd_ptr_q];
            end
        end
    end

    assign bus.rf_we_o        = rf_we;
    assign bus.rf_rd_o        = rf_rd;
    assign bus.rf_data_o      = rf_data;
    assign bus.llu_ready_o    = llu_ready;
    assign bus.fifo_count_o   = cnt_q;
    assign bus.wb_hold_o      = rst_i & (state_q == StForce);
    assign bus.hazard_stall_o = rst_i & (pending_q[bus.rs1_label_i] |
                                         pending_q[bus.rs2_label_i] |
                                         pending_q[bus.rd_label_i]);

    // Next-state for FIFO occupancy, starvation counter, FSM and scoreboard.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(enq) - CNT_W'(fifo_gnt);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(fifo_gnt);

        starve_d = starve_q;
        if (fifo_gnt) begin
            starve_d = '0;
        end else if (pipe_gnt && (cnt_q != '0) && (starve_q != STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end

        // FORCE always dequeues, so the counter is cleared and FORCE never repeats.
        if (cnt_d == '0)                            state_d = StIdle;
        else if (starve_d >= STV_W'(STARVE_LIMIT)) state_d = StForce;
        else                                        state_d = StDrain;

        pending_d = pending_q;
        if (fifo_gnt)        pending_d[mem_rd[rd_ptr_q]] = 1'b0;
        if (bus.llu_issue_i) pending_d[bus.llu_issue_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Control state; reset discards any buffered results.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            starve_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
    end

    // FIFO storage; contents are only meaningful under the count.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_rd[wr_ptr_q]   <= bus.llu_rd_i;
            mem_data[wr_ptr_q] <= bus.llu_data_i;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(32), .FIFO_DEPTH(2)) bus ();

    wb_port_arbiter #(
        .DATA_W      (32),
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_wb_en_i   = 1'b0;
        bus.pipe_wb_rd_i   = 5'd0;
        bus.pipe_wb_data_i = 32'd0;
        bus.llu_issue_i    = 1'b0;
        bus.llu_issue_rd_i = 5'd0;
        bus.llu_valid_i    = 1'b0;
        bus.llu_rd_i       = 5'd0;
        bus.llu_data_i     = 32'd0;
        bus.rs1_label_i    = 5'd0;
        bus.rs2_label_i    = 5'd0;
        bus.rd_label_i     = 5'd0;
    endtask

    task automatic set_pipe(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.pipe_wb_en_i   = en;
        bus.pipe_wb_rd_i   = rd;
        bus.pipe_wb_data_i = data;
    endtask

    task automatic set_llu(input logic vld, input logic [4:0] rd, input logic [31:0] data);
        bus.llu_valid_i = vld;
        bus.llu_rd_i    = rd;
        bus.llu_data_i  = data;
    endtask

    task automatic set_issue(input logic en, input logic [4:0] rd);
        bus.llu_issue_i    = en;
        bus.llu_issue_rd_i = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        // Pipe request during reset must not reach the write port.
        set_pipe(1'b1, 5'd3, 32'h33);
        @(negedge clk);
        check_eq("rst_we",    64'(bus.rf_we_o), 64'd0);
        check_eq("rst_count", 64'(bus.fifo_count_o), 64'd0);
        check_eq("rst_ready", 64'(bus.llu_ready_o), 64'd0);

        next_cycle();
        rst_n = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);

        // Idle LLU return to x7.
        next_cycle();
        set_issue(1'b1, 5'd7);
        @(negedge clk);
        check_eq("t1_we0", 64'(bus.rf_we_o), 64'd0);
        next_cycle();
        set_issue(1'b0, 5'd0);
        set_llu(1'b1, 5'd7, 32'hDEADBEEF);
        bus.rs1_label_i = 5'd7;
        @(negedge clk);
        check_eq("t1_ready",  64'(bus.llu_ready_o), 64'd1);
        check_eq("t1_haz",    64'(bus.hazard_stall_o), 64'd1);
        check_eq("t1_nopass", 64'(bus.rf_we_o), 64'd0);
        next_cycle();
        set_llu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd0, 32'h1234);  // x0 request must not win
        @(negedge clk);
        check_eq("t1_we",    64'(bus.rf_we_o), 64'd1);
        check_eq("t1_rd",    64'(bus.rf_rd_o), 64'd7);
        check_eq("t1_data",  64'(bus.rf_data_o), 64'hDEADBEEF);
        check_eq("t1_cnt1",  64'(bus.fifo_count_o), 64'd1);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check_eq("t1_cnt0",  64'(bus.fifo_count_o), 64'd0);
        check_eq("t1_idle",  64'(bus.rf_we_o), 64'd0);
        check_eq("t1_clr",   64'(bus.hazard_stall_o), 64'd0);
        bus.rs1_label_i = 5'd0;

        // Collision: pipe x3 every cycle against a buffered x9.
        next_cycle();
        set_pipe(1'b1, 5'd3, 32'h33);
        set_llu(1'b1, 5'd9, 32'h99);
        @(negedge clk);
        check_eq("t2_first", 64'(bus.rf_rd_o), 64'd3);
        next_cycle();
        set_llu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t2_pipe_rd",   64'(bus.rf_rd_o), 64'd3);
            check_eq("t2_pipe_hold", 64'(bus.wb_hold_o), 64'd0);
            next_cycle();
        end
        @(negedge clk);
        check_eq("t2_force_hold", 64'(bus.wb_hold_o), 64'd1);
        check_eq("t2_force_rd",   64'(bus.rf_rd_o), 64'd9);
        check_eq("t2_force_data", 64'(bus.rf_data_o), 64'h99);
        next_cycle();
        @(negedge clk);
        check_eq("t2_after_hold", 64'(bus.wb_hold_o), 64'd0);
        check_eq("t2_after_rd",   64'(bus.rf_rd_o), 64'd3);
        check_eq("t2_after_cnt",  64'(bus.fifo_count_o), 64'd0);

        // Backpressure with the pipe always requesting.
        next_cycle();
        set_llu(1'b1, 5'd10, 32'hA);
        @(negedge clk);
        check_eq("t3_c1_ready", 64'(bus.llu_ready_o), 64'd1);
        next_cycle();
        set_llu(1'b1, 5'd11, 32'hB);
        @(negedge clk);
        check_eq("t3_c2_ready", 64'(bus.llu_ready_o), 64'd1);
        check_eq("t3_c2_cnt",   64'(bus.fifo_count_o), 64'd1);
        next_cycle();
        set_llu(1'b1, 5'd12, 32'hC);
        @(negedge clk);
        check_eq("t3_c3_ready", 64'(bus.llu_ready_o), 64'd0);
        check_eq("t3_c3_cnt",   64'(bus.fifo_count_o), 64'd2);
        next_cycle();
        @(negedge clk);
        check_eq("t3_c4_ready", 64'(bus.llu_ready_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check_eq("t3_c5_hold",  64'(bus.wb_hold_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check_eq("t3_c6_hold",  64'(bus.wb_hold_o), 64'd1);
        check_eq("t3_c6_rd",    64'(bus.rf_rd_o), 64'd10);
        check_eq("t3_c6_ready", 64'(bus.llu_ready_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check_eq("t3_c7_ready", 64'(bus.llu_ready_o), 64'd1);
        check_eq("t3_c7_rd",    64'(bus.rf_rd_o), 64'd3);
        check_eq("t3_c7_cnt",   64'(bus.fifo_count_o), 64'd1);
        next_cycle();
        set_llu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check_eq("t3_c8_rd",   64'(bus.rf_rd_o), 64'd11);
        check_eq("t3_c8_data", 64'(bus.rf_data_o), 64'hB);
        check_eq("t3_c8_cnt",  64'(bus.fifo_count_o), 64'd2);
        next_cycle();
        @(negedge clk);
        check_eq("t3_c9_rd",   64'(bus.rf_rd_o), 64'd12);
        check_eq("t3_c9_data", 64'(bus.rf_data_o), 64'hC);
        next_cycle();
        @(negedge clk);
        check_eq("t3_c10_cnt", 64'(bus.fifo_count_o), 64'd0);
        check_eq("t3_c10_we",  64'(bus.rf_we_o), 64'd0);

        // Scoreboard RAW/WAW on x12.
        next_cycle();
        set_issue(1'b1, 5'd12);
        bus.rs2_label_i = 5'd12;
        @(negedge clk);
        check_eq("t4_pre", 64'(bus.hazard_stall_o), 64'd0);
        next_cycle();
        set_issue(1'b0, 5'd0);
        @(negedge clk);
        check_eq("t4_rs2", 64'(bus.hazard_stall_o), 64'd1);
        bus.rs2_label_i = 5'd0;
        #1;
        check_eq("t4_x0", 64'(bus.hazard_stall_o), 64'd0);
        bus.rd_label_i = 5'd12;
        #1;
        check_eq("t4_waw", 64'(bus.hazard_stall_o), 64'd1);
        bus.rd_label_i  = 5'd0;
        bus.rs2_label_i = 5'd12;
        next_cycle();
        set_llu(1'b1, 5'd12, 32'hC12);
        @(negedge clk);
        check_eq("t4_ret", 64'(bus.hazard_stall_o), 64'd1);
        next_cycle();
        set_llu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check_eq("t4_wr_rd",  64'(bus.rf_rd_o), 64'd12);
        check_eq("t4_wr_haz", 64'(bus.hazard_stall_o), 64'd1);
        next_cycle();
        @(negedge clk);
        check_eq("t4_done", 64'(bus.hazard_stall_o), 64'd0);
        bus.rs2_label_i = 5'd0;

        // Set/clear race on x4: set wins.
        next_cycle();
        set_issue(1'b1, 5'd4);
        set_llu(1'b1, 5'd4, 32'h44);
        @(negedge clk);
        check_eq("t5_we0", 64'(bus.rf_we_o), 64'd0);
        next_cycle();
        set_llu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check_eq("t5_wr_rd", 64'(bus.rf_rd_o), 64'd4);
        next_cycle();
        set_issue(1'b0, 5'd0);
        bus.rd_label_i = 5'd4;
        set_llu(1'b1, 5'd4, 32'h45);
        @(negedge clk);
        check_eq("t5_kept", 64'(bus.hazard_stall_o), 64'd1);
        check_eq("t5_cnt",  64'(bus.fifo_count_o), 64'd0);
        next_cycle();
        set_llu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check_eq("t5_wr2", 64'(bus.rf_data_o), 64'h45);
        next_cycle();
        @(negedge clk);
        check_eq("t5_clr", 64'(bus.hazard_stall_o), 64'd0);
        bus.rd_label_i = 5'd0;

        // LLU result to x0 is dropped.
        next_cycle();
        set_llu(1'b1, 5'd0, 32'h77);
        @(negedge clk);
        check_eq("t6_ready", 64'(bus.llu_ready_o), 64'd1);
        next_cycle();
        set_llu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check_eq("t6_cnt", 64'(bus.fifo_count_o), 64'd0);
        check_eq("t6_we",  64'(bus.rf_we_o), 64'd0);

        // Asynchronous reset mid-operation.
        next_cycle();
        set_issue(1'b1, 5'd5);
        set_llu(1'b1, 5'd6, 32'h66);
        next_cycle();
        set_issue(1'b0, 5'd0);
        set_llu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd3, 32'h33);
        bus.rs1_label_i = 5'd5;
        @(negedge clk);
        check_eq("t7_pre_cnt", 64'(bus.fifo_count_o), 64'd1);
        check_eq("t7_pre_haz", 64'(bus.hazard_stall_o), 64'd1);
        check_eq("t7_pre_rd",  64'(bus.rf_rd_o), 64'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t7_we",    64'(bus.rf_we_o), 64'd0);
        check_eq("t7_rd",    64'(bus.rf_rd_o), 64'd0);
        check_eq("t7_data",  64'(bus.rf_data_o), 64'd0);
        check_eq("t7_hold",  64'(bus.wb_hold_o), 64'd0);
        check_eq("t7_haz",   64'(bus.hazard_stall_o), 64'd0);
        check_eq("t7_ready", 64'(bus.llu_ready_o), 64'd0);
        check_eq("t7_cnt",   64'(bus.fifo_count_o), 64'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t7_post_cnt", 64'(bus.fifo_count_o), 64'd0);
        check_eq("t7_post_haz", 64'(bus.hazard_stall_o), 64'd0);
        check_eq("t7_post_we",  64'(bus.rf_we_o), 64'd1);
        check_eq("t7_post_rd",  64'(bus.rf_rd_o), 64'd3);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_eq("t7_empty_we",  64'(bus.rf_we_o), 64'd0);
        check_eq("t7_empty_cnt", 64'(bus.fifo_count_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
